// File: rtl/gowin_rst_btn_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gowin_rst_btn_cond_pkg
// Brief    : Shared constants and FSM state encoding for the reset-button conditioner.
// Revision : 1.0
// ============================================================================
package gowin_rst_btn_cond_pkg;

  localparam int unsigned CLK_HZ              = 27_000_000;
  // 10 ms debounce window and 1 us minimum reset width at the board clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int unsigned PULSE_CYCLES_DEF    = CLK_HZ / 1_000_000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_PULSE = 2'd0;
  localparam state_t ST_HOLD  = 2'd1;
  localparam state_t ST_IDLE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/gowin_rst_btn_cond_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Button synchroniser plus stable-count debouncer, pressed = 1.
// Revision : 1.0
// ============================================================================
module btn_debounce
  import gowin_rst_btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn_db
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   s_btn;

  assign s_btn = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
    db_d   = db_q;
    cnt_d  = '0;
    // Counter only runs while the synchronised level disagrees with the output
    if (s_btn != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign o_btn_db = db_q;

endmodule
`default_nettype wire

// File: rtl/gowin_rst_btn_cond.sv
`default_nettype none
// ============================================================================
// Module   : gowin_rst_btn_cond
// Brief    : Debounced, minimum-width PLL reset from the board button plus power-on pulse.
// Revision : 1.0
// ============================================================================
module gowin_rst_btn_cond
  import gowin_rst_btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rst,
  output logic o_btn_db,
  output logic o_press
);

  localparam int unsigned   PW         = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(1);

  logic          btn_db;
  logic          db_prev_q;
  logic          rise;
  logic          press_q;
  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          rst_q, rst_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_btn    (i_btn),
    .o_btn_db (btn_db)
  );

  assign rise = btn_db & ~db_prev_q;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      ST_PULSE: begin
        pcnt_d = pcnt_q - 1'b1;
        if (pcnt_q == PULSE_LAST) begin
          state_d = btn_db ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!btn_db) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // Presses only retrigger from IDLE; PULSE/HOLD absorb them
        if (rise) begin
          state_d = ST_PULSE;
          pcnt_d  = PULSE_LOAD;
        end
      end
      default: begin
        state_d = ST_PULSE;
        pcnt_d  = PULSE_LOAD;
      end
    endcase
    rst_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_PULSE;
      pcnt_q    <= PULSE_LOAD;
      rst_q     <= 1'b1;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      rst_q     <= rst_d;
      db_prev_q <= btn_db;
      press_q   <= rise;
    end
  end

  assign o_rst    = rst_q;
  assign o_btn_db = btn_db;
  assign o_press  = press_q;

endmodule
`default_nettype wire

// File: tb/tb_gowin_rst_btn_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_gowin_rst_btn_cond
// Brief    : Scoreboard bench for gowin_rst_btn_cond with a timeline-based reference model.
// Revision : 1.0
// ============================================================================
module tb_gowin_rst_btn_cond;

  localparam int unsigned DEB  = 8;
  localparam int unsigned PUL  = 4;
  localparam int unsigned SYNC = 2;
  localparam bit          AL   = 1'b1;

  typedef struct packed {
    logic rst;
    logic db;
    logic press;
  } exp_t;

  logic clk;
  logic i_rst;
  logic i_btn;
  logic o_rst;
  logic o_btn_db;
  logic o_press;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t sb_q[$];

  gowin_rst_btn_cond #(
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_CYCLES    (PUL),
    .BTN_ACTIVE_LOW  (AL),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_btn    (i_btn),
    .o_rst    (o_rst),
    .o_btn_db (o_btn_db),
    .o_press  (o_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pin history delayed by the synchroniser, debounced level
  // flips when the last DEB samples all disagree, reset output follows a
  // timeline of "pulse ends at cycle N" plus a hold-while-pressed flag.
  bit m_pins[$];
  bit m_samp[$];
  bit m_db, m_prev, m_hold, m_started;
  int m_k = 0;
  int m_pulse_until = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   s, all_diff, db_old, prev_old;
    m_k++;
    e = '0;
    if (i_rst) begin
      m_started = 1'b1;
      m_pins = {};
      for (int i = 0; i < SYNC; i++) m_pins.push_back(AL);
      m_samp = {};
      m_db = 1'b0;
      m_prev = 1'b0;
      m_hold = 1'b0;
      m_pulse_until = m_k + PUL;
      e.rst = 1'b1;
    end else if (m_started) begin
      db_old   = m_db;
      prev_old = m_prev;
      s = m_pins.pop_front() ^ AL;
      m_pins.push_back(i_btn);
      m_samp.push_back(s);
      if (m_samp.size() > DEB) void'(m_samp.pop_front());
      all_diff = (m_samp.size() == DEB);
      foreach (m_samp[i]) if (m_samp[i] == db_old) all_diff = 1'b0;
      if (all_diff) begin
        m_db = ~db_old;
        m_samp = {};
      end
      m_prev  = db_old;
      e.press = db_old & ~prev_old;
      if (m_k < m_pulse_until) begin
        e.rst = 1'b1;
      end else if (m_k == m_pulse_until) begin
        m_hold = db_old;
        e.rst  = db_old;
      end else if (m_hold) begin
        m_hold = db_old;
        e.rst  = db_old;
      end else if (e.press) begin
        m_pulse_until = m_k + PUL;
        e.rst = 1'b1;
      end
      e.db = m_db;
    end
    if (m_started) sb_q.push_back(e);
  end

  task automatic chk(input string nm, input logic act, input logic exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0b expected %0b", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m_started) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty at t=%0t: got 0 entries expected 1", $time);
      end else begin
        e = sb_q.pop_front();
        chk("o_rst", o_rst, e.rst);
        chk("o_btn_db", o_btn_db, e.db);
        chk("o_press", o_press, e.press);
      end
    end
  end

  task automatic hold(input logic lvl, input int n);
    i_btn = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rst(input int n);
    i_rst = 1'b1;
    repeat (n) @(negedge clk);
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_btn = 1'b1;
    @(negedge clk);
    do_rst(2);
    hold(1'b1, 12);
    // clean press
    hold(1'b0, 40);
    hold(1'b1, 30);
    // glitches of 1, 5 and 7 cycles
    hold(1'b0, 1);  hold(1'b1, 10);
    hold(1'b0, 5);  hold(1'b1, 10);
    hold(1'b0, 7);  hold(1'b1, 10);
    // short tap
    hold(1'b0, 10);
    hold(1'b1, 30);
    // bouncy release
    hold(1'b0, 40);
    for (int i = 0; i < 7; i++) hold(i[0] ? 1'b0 : 1'b1, 3);
    hold(1'b1, 30);
    // reset mid-HOLD, pin still pressed
    hold(1'b0, 30);
    do_rst(1);
    hold(1'b0, 30);
    hold(1'b1, 30);
    // reset mid-HOLD, pin released at reset
    hold(1'b0, 30);
    i_btn = 1'b1;
    do_rst(1);
    hold(1'b1, 30);
    // press landing inside the power-on pulse
    i_btn = 1'b0;
    do_rst(1);
    hold(1'b0, 20);
    hold(1'b1, 20);
    // random stimulus
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) do_rst($urandom_range(1, 3));
      hold(1'(($urandom % 2)), $urandom_range(1, 20));
    end
    hold(1'b1, 30);
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
